// File: rtl/shared_drive_arbiter.sv
// shared_drive_arbiter: round-robin exclusive ownership of one shared WIDTH-bit signal.
// The owner's data is registered onto o_bus. Any drive from a channel that does not
// hold the grant is reported as a conflict.
// Optional build macro SHARED_DRIVE_WOR_EN: o_bus becomes the wired-OR of every
// enabled channel's data instead of the owner's data only.
module shared_drive_arbiter #(
  parameter int unsigned N_CHAN         = 4,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_HOLD       = 16,
  parameter int unsigned CONFLICT_CNT_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_CHAN-1:0]         i_req,
  input  logic [N_CHAN-1:0]         i_en,
  input  logic [N_CHAN*WIDTH-1:0]   i_data,
  output logic [N_CHAN-1:0]         o_gnt,
  output logic [WIDTH-1:0]          o_bus,
  output logic                      o_bus_valid,
  output logic                      o_conflict,
  output logic [N_CHAN-1:0]         o_conflict_chan,
  output logic [CONFLICT_CNT_W-1:0] o_conflict_cnt
);

  localparam int unsigned CHAN_W        = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int unsigned HOLD_W        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LAST_INT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LAST_INT);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e              state_q;
  logic [CHAN_W-1:0]   rr_q;
  logic [CHAN_W-1:0]   owner_q;
  logic [HOLD_W-1:0]   hold_q;

  logic                pick_found;
  logic [CHAN_W-1:0]   pick_idx;
  logic [N_CHAN-1:0]   pick_onehot;
  logic [CHAN_W-1:0]   next_rr;
  logic                grant_end;
  logic [N_CHAN-1:0]   conflict_mask;
  logic                bus_valid_d;
  logic [WIDTH-1:0]    bus_d;

  // Round-robin pick: first requester at or above rr_q, wrapping past the top channel.
  always_comb begin : arb_pick
    logic [CHAN_W-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      cand = CHAN_W'((32'(rr_q) + i) % N_CHAN);
      if (!pick_found && i_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // One-hot form of the pick plus ownership-end and pointer-advance decisions.
  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
    next_rr   = (32'(owner_q) == N_CHAN - 1) ? '0 : owner_q + CHAN_W'(1);
    grant_end = !i_req[owner_q] || ((MAX_HOLD != 0) && (hold_q == HOLD_LAST));
    // The owner's own drive is never a conflict.
    conflict_mask = i_en & ~o_gnt;
  end

`ifdef SHARED_DRIVE_WOR_EN
  // Wired-OR resolution across every enabled channel.
  always_comb begin
    bus_valid_d = |i_en;
    bus_d       = '0;
    for (int unsigned k = 0; k < N_CHAN; k++) begin
      if (i_en[k]) begin
        bus_d = bus_d | i_data[k*WIDTH +: WIDTH];
      end
    end
  end
`else
  // Only the current owner's data reaches the bus.
  always_comb begin
    bus_valid_d = |(o_gnt & i_en);
    bus_d       = i_data[32'(owner_q)*WIDTH +: WIDTH];
  end
`endif

  // Ownership FSM with registered grant, bus and conflict outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= StIdle;
      rr_q            <= '0;
      owner_q         <= '0;
      hold_q          <= '0;
      o_gnt           <= '0;
      o_bus           <= '0;
      o_bus_valid     <= 1'b0;
      o_conflict      <= 1'b0;
      o_conflict_chan <= '0;
      o_conflict_cnt  <= '0;
    end else begin
      case (state_q)
        StIdle, StRelease: begin
          if (pick_found) begin
            state_q <= StGrant;
            o_gnt   <= pick_onehot;
            owner_q <= pick_idx;
            hold_q  <= '0;
          end else begin
            state_q <= StIdle;
            o_gnt   <= '0;
          end
        end
        StGrant: begin
          if (grant_end) begin
            // One-cycle turnaround; the next owner search starts past this one.
            state_q <= StRelease;
            o_gnt   <= '0;
            rr_q    <= next_rr;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          o_gnt   <= '0;
        end
      endcase

      o_bus_valid <= bus_valid_d;
      if (bus_valid_d) begin
        o_bus <= bus_d;
      end

      o_conflict <= |conflict_mask;
      if (|conflict_mask) begin
        o_conflict_chan <= conflict_mask;
        if (o_conflict_cnt != '1) begin
          o_conflict_cnt <= o_conflict_cnt + CONFLICT_CNT_W'(1);
        end
      end
    end
  end

endmodule
